// File: rtl/sketch_pkg.sv
// Shared widths, latency and stage-carry type for the sketch colour-dodge blend.
// The divider pipeline passes one div_stage_t per stage.
package sketch_pkg;

    localparam int PIX_W         = 8;
    localparam int NUM_W         = 16;
    localparam int REM_W         = 9;
    localparam int DIV_STAGES    = NUM_W;
    localparam int DODGE_LATENCY = DIV_STAGES + 2;

    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    // Everything one restoring step needs travels together, so adjacent pixels
    // with different divisors never share state.
    typedef struct packed {
        logic [REM_W-1:0] rem;
        logic [NUM_W-1:0] num;
        logic [PIX_W-1:0] div;
        logic             dz;
        logic [NUM_W-1:0] quo;
    } div_stage_t;

    // Divide-by-zero and any quotient above one pixel clip to white.
    function automatic logic [PIX_W-1:0] dodge_saturate(
        input logic [NUM_W-1:0] quo,
        input logic             dz
    );
        if (dz || (|quo[NUM_W-1:PIX_W])) begin
            return PIX_MAX;
        end
        return quo[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sketch_dodge_blend_if.sv
// Pixel-stream bundle between the Gaussian filter and the dodge blend stage.
// The block takes the slave view; a source or bench takes the master view.
interface sketch_dodge_blend_if;
    import sketch_pkg::*;

    logic             pre_vs;
    logic             pre_de;
    logic [PIX_W-1:0] pre_blur;
    logic [PIX_W-1:0] pre_orig;

    logic             post_vs;
    logic             post_de;
    logic [PIX_W-1:0] post_data;

    modport master (
        output pre_vs,
        output pre_de,
        output pre_blur,
        output pre_orig,
        input  post_vs,
        input  post_de,
        input  post_data
    );

    modport slave (
        input  pre_vs,
        input  pre_de,
        input  pre_blur,
        input  pre_orig,
        output post_vs,
        output post_de,
        output post_data
    );

endinterface

// File: rtl/sketch_div_stage.sv
// One registered restoring-division step: brings down the next numerator bit,
// subtracts the divisor when it fits and shifts the resulting quotient bit in.
module sketch_div_stage
    import sketch_pkg::*;
(
    input  logic       clk,
    input  div_stage_t stage_i,
    output div_stage_t stage_o
);

    logic [REM_W:0] trial_rem;
    logic [REM_W:0] div_ext;
    logic           take;
    div_stage_t     stage_d;
    div_stage_t     stage_q;

    // The remainder stays below the divisor, so the truncation back to
    // REM_W bits after the subtract never loses information.
    always_comb begin
        trial_rem     = {stage_i.rem, stage_i.num[NUM_W-1]};
        div_ext       = {{(REM_W + 1 - PIX_W){1'b0}}, stage_i.div};
        take          = (trial_rem >= div_ext);
        stage_d       = stage_i;
        stage_d.num   = {stage_i.num[NUM_W-2:0], 1'b0};
        stage_d.quo   = {stage_i.quo[NUM_W-2:0], take};
        stage_d.rem   = take ? REM_W'(trial_rem - div_ext) : trial_rem[REM_W-1:0];
    end

    // Data path only: no reset, no enable; invalid slots are masked downstream.
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/sketch_dodge_blend.sv
// Colour-dodge blend: out = min(255, orig*255 / (255 - blur)), one pixel per
// clock through a 16-step restoring divider, vs/de delayed to stay aligned.
module sketch_dodge_blend
    import sketch_pkg::*;
#(
    parameter bit INVERT_BLUR = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    sketch_dodge_blend_if.slave  bus
);

    logic [PIX_W-1:0] blur_eff;
    logic [PIX_W-1:0] div_in;
    logic [NUM_W-1:0] num_in;
    div_stage_t       stage0_d;
    div_stage_t       stage0_q;

    // orig*255 is formed as orig*256 - orig to avoid a multiplier.
    always_comb begin
        blur_eff     = INVERT_BLUR ? (PIX_MAX - bus.pre_blur) : bus.pre_blur;
        div_in       = PIX_MAX - blur_eff;
        num_in       = {bus.pre_orig, {PIX_W{1'b0}}} - NUM_W'(bus.pre_orig);
        stage0_d     = '0;
        stage0_d.num = num_in;
        stage0_d.div = div_in;
        stage0_d.dz  = (div_in == '0);
    end

    always_ff @(posedge clk) begin
        stage0_q <= stage0_d;
    end

    div_stage_t stage_w [DIV_STAGES+1];

    assign stage_w[0] = stage0_q;

    generate
        for (genvar gi = 0; gi < DIV_STAGES; gi++) begin : g_div
            sketch_div_stage u_stage (
                .clk     (clk),
                .stage_i (stage_w[gi]),
                .stage_o (stage_w[gi+1])
            );
        end
    endgenerate

    // Bit k of each delay line is co-timed with divider stage k.
    logic [DODGE_LATENCY-1:0] vs_sr_q;
    logic [DODGE_LATENCY-1:0] de_sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_sr_q <= '0;
            de_sr_q <= '0;
        end else begin
            vs_sr_q <= {vs_sr_q[DODGE_LATENCY-2:0], bus.pre_vs};
            de_sr_q <= {de_sr_q[DODGE_LATENCY-2:0], bus.pre_de};
        end
    end

    logic [PIX_W-1:0] post_data_d;
    logic [PIX_W-1:0] post_data_q;

    always_comb begin
        post_data_d = '0;
        if (de_sr_q[DODGE_LATENCY-2]) begin
            post_data_d = dodge_saturate(stage_w[DIV_STAGES].quo, stage_w[DIV_STAGES].dz);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            post_data_q <= '0;
        end else begin
            post_data_q <= post_data_d;
        end
    end

    assign bus.post_vs   = vs_sr_q[DODGE_LATENCY-1];
    assign bus.post_de   = de_sr_q[DODGE_LATENCY-1];
    assign bus.post_data = post_data_q;

    // Final remainder, drained numerator and divisor copy have no consumer.
    logic unused_tail;
    assign unused_tail = ^{stage_w[DIV_STAGES].rem, stage_w[DIV_STAGES].num,
                           stage_w[DIV_STAGES].div};

endmodule

// File: tb/tb_sketch_dodge_blend.sv
// Scoreboard bench for sketch_dodge_blend: directed vectors on a normal and an
// inverted-blur instance, then a gapped 16x8 frame with a mid-line reset.
module tb_sketch_dodge_blend;
    import sketch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sketch_dodge_blend_if if0 ();
    sketch_dodge_blend_if if1 ();

    sketch_dodge_blend #(.INVERT_BLUR(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sketch_dodge_blend #(.INVERT_BLUR(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic       vs;
        logic [7:0] data;
        int         issue;
        string      tag;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp      = 0;
    int   n_bad      = 0;
    int   cyc        = 0;
    int   quiet_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic compare_pix(input string who, input exp_t e, input logic vs,
                               input logic [7:0] data);
        check({who, "_", e.tag, "_data"}, int'(data), int'(e.data));
        check({who, "_", e.tag, "_vs"}, int'(vs), int'(e.vs));
        check({who, "_", e.tag, "_latency"}, cyc - e.issue, DODGE_LATENCY);
        $display("%s pixel %s: data=%0d exp=%0d vs=%0b lat=%0d", who, e.tag, data, e.data,
                 vs, cyc - e.issue);
    endtask

    // Monitors: pop on every valid output, demand zero data on every idle one.
    always @(negedge clk) begin
        exp_t e;
        if (if0.post_de) begin
            if (q0.size() == 0) check("dut0_unexpected_de", 1, 0);
            else begin
                e = q0.pop_front();
                compare_pix("dut0", e, if0.post_vs, if0.post_data);
            end
        end else begin
            check("dut0_idle_data_zero", int'(if0.post_data), 0);
        end
        if (quiet_left > 0) begin
            check("post_reset_de_low", int'(if0.post_de), 0);
            check("post_reset_vs_low", int'(if0.post_vs), 0);
            quiet_left--;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (if1.post_de) begin
            if (q1.size() == 0) check("dut1_unexpected_de", 1, 0);
            else begin
                e = q1.pop_front();
                compare_pix("dut1", e, if1.post_vs, if1.post_data);
            end
        end else begin
            check("dut1_idle_data_zero", int'(if1.post_data), 0);
        end
    end

    task automatic drive(input bit which, input bit vs, input bit de, input int orig,
                         input int blur, input int exp, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if0.pre_vs = 1'b0; if0.pre_de = 1'b0;
        if1.pre_vs = 1'b0; if1.pre_de = 1'b0;
        if (which == 1'b0) begin
            if0.pre_vs = vs; if0.pre_de = de;
            if0.pre_orig = orig[7:0]; if0.pre_blur = blur[7:0];
        end else begin
            if1.pre_vs = vs; if1.pre_de = de;
            if1.pre_orig = orig[7:0]; if1.pre_blur = blur[7:0];
        end
        if (de) begin
            e.vs = vs; e.data = exp[7:0]; e.issue = cyc; e.tag = tag;
            if (which == 1'b0) q0.push_back(e);
            else q1.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 0, 0, 0, "idle");
    endtask

    function automatic int ref_dodge(input int orig, input int blur);
        int d;
        int q;
        d = 255 - blur;
        if (d == 0) return 255;
        q = (orig * 255) / d;
        return (q > 255) ? 255 : q;
    endfunction

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        if0.pre_de = 1'b0; if0.pre_vs = 1'b0;
        if1.pre_de = 1'b0; if1.pre_vs = 1'b0;
        @(posedge clk);
        #1;
        $display("reset pulse: dropping %0d in-flight pixels", q0.size() + q1.size());
        q0.delete();
        q1.delete();
        quiet_left = DODGE_LATENCY;
        rst = 1'b0;
    endtask

    initial begin
        int orig;
        int blur;
        if0.pre_vs = 1'b0; if0.pre_de = 1'b0; if0.pre_orig = '0; if0.pre_blur = '0;
        if1.pre_vs = 1'b0; if1.pre_de = 1'b0; if1.pre_orig = '0; if1.pre_blur = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_post_vs", int'(if0.post_vs), 0);
        check("reset_post_de", int'(if0.post_de), 0);
        check("reset_post_data", int'(if0.post_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        drive(1'b0, 1'b1, 1'b1, 128, 0, 128, "b0_identity");
        idle(2);
        drive(1'b0, 1'b0, 1'b1, 60, 135, 127, "floor");
        drive(1'b0, 1'b0, 1'b1, 100, 155, 255, "exact255");
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 0, 255, 255, "dz_orig0");
        drive(1'b0, 1'b0, 1'b1, 200, 255, 255, "dz_orig200");
        drive(1'b0, 1'b0, 1'b1, 0, 10, 0, "orig0");
        idle(3);
        drive(1'b0, 1'b0, 1'b1, 128, 0, 128, "b2b_a");
        drive(1'b0, 1'b0, 1'b1, 60, 135, 127, "b2b_b");
        drive(1'b0, 1'b0, 1'b1, 10, 250, 255, "b2b_c");
        drive(1'b0, 1'b0, 1'b1, 200, 100, 255, "b2b_d");
        drive(1'b0, 1'b0, 1'b1, 255, 0, 255, "max_identity");
        drive(1'b0, 1'b0, 1'b1, 1, 254, 255, "d1");
        drive(1'b0, 1'b0, 1'b1, 37, 0, 37, "identity37");
        drive(1'b0, 1'b0, 1'b1, 50, 200, 231, "d55");
        drive(1'b1, 1'b0, 1'b1, 128, 255, 128, "inv_b0");
        drive(1'b1, 1'b0, 1'b1, 60, 120, 127, "inv_floor");
        drive(1'b1, 1'b1, 1'b1, 200, 0, 255, "inv_dz");
        idle(24);

        // 16x8 frame, vs high along the first line, gaps and blanking in de.
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                if (y == 3 && x == 8) pulse_reset();
                if ((x == 5 && (y % 2) == 0) || (x == 11 && y == 6)) idle(1);
                orig = (x * 37 + y * 53 + 11) % 256;
                blur = (x == 15) ? 255 : (x * 29 + y * 61) % 256;
                drive(1'b0, (y == 0), 1'b1, orig, blur, ref_dodge(orig, blur), "frame");
            end
            idle(3);
        end

        for (int i = 0; i < 40 && (q0.size() + q1.size()) > 0; i++) @(posedge clk);
        check("drain_pending", q0.size() + q1.size(), 0);
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
